// File: rtl/ysyx_22050078_exu_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface ysyx_22050078_exu_muldiv_if #(
  parameter int unsigned WIDTH = 64
);
  logic             i_valid;
  logic [2:0]       i_func3;
  logic             i_word;
  logic [WIDTH-1:0] i_rs1;
  logic [WIDTH-1:0] i_rs2;
  logic             i_flush;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_valid, i_func3, i_word, i_rs1, i_rs2, i_flush,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_func3, i_word, i_rs1, i_rs2, i_flush,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/ysyx_22050078_exu_muldiv.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply, radix-2 restoring divide.
// Operands are reduced to magnitudes on entry; signs are fixed up on the final iteration.
module ysyx_22050078_exu_muldiv #(
  parameter int unsigned WIDTH = 64
) (
  input logic                         clk,
  input logic                         rst_n,
  ysyx_22050078_exu_muldiv_if.slave   bus
);
  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;      // product, or {remainder, dividend/quotient}
  logic [W2-1:0]    mcand_q, mcand_d;  // shifted multiplicand
  logic [WIDTH-1:0] opb_q, opb_d;      // multiplier (shifts right) or divisor
  logic             is_div_q, is_div_d;
  logic             hi_q, hi_d;        // mul: high half; div: remainder
  logic             word_q, word_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
    return {{(WIDTH-32){v[31]}}, v};
  endfunction

  // Decode of the incoming request: signedness, magnitudes and fast-path detection.
  logic [2:0]       f3;
  logic             is_mulh, is_div, word_eff, a_signed, b_signed;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, dvd_raw, min_val, fast_res;
  logic             a_neg, b_neg, div_zero, div_ovf;

  always_comb begin
    f3       = bus.i_func3;
    is_mulh  = ~f3[2] & (f3[1] | f3[0]);
    is_div   = f3[2];
    word_eff = bus.i_word & ~is_mulh;
    a_signed = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
    b_signed = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
    if (word_eff) begin
      a_ext = a_signed ? sext32(bus.i_rs1[31:0]) : {{(WIDTH-32){1'b0}}, bus.i_rs1[31:0]};
      b_ext = b_signed ? sext32(bus.i_rs2[31:0]) : {{(WIDTH-32){1'b0}}, bus.i_rs2[31:0]};
    end else begin
      a_ext = bus.i_rs1;
      b_ext = bus.i_rs2;
    end
    a_neg    = a_signed & a_ext[WIDTH-1];
    b_neg    = b_signed & b_ext[WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    dvd_raw  = word_eff ? sext32(bus.i_rs1[31:0]) : bus.i_rs1;
    min_val  = word_eff ? sext32(32'h8000_0000) : MinNeg;
    div_zero = (b_ext == '0);
    div_ovf  = a_signed & (a_ext == min_val) & (b_ext == '1);
    if (div_zero) fast_res = f3[1] ? dvd_raw : '1;
    else          fast_res = f3[1] ? '0 : dvd_raw;
  end

  // One radix-2 step plus the sign-fixed, width-selected result it would yield if final.
  logic [W2-1:0]    acc_it, prod;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] quot, rem, res_full, fin;

  always_comb begin
    shifted = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    ge      = ~diff[WIDTH];
    if (is_div_q) begin
      acc_it = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      acc_it = acc_q + (opb_q[0] ? mcand_q : '0);
    end
    prod     = qneg_q ? -acc_it : acc_it;
    quot     = qneg_q ? -acc_it[WIDTH-1:0] : acc_it[WIDTH-1:0];
    rem      = rneg_q ? -acc_it[W2-1:WIDTH] : acc_it[W2-1:WIDTH];
    if (is_div_q) res_full = hi_q ? rem : quot;
    else          res_full = hi_q ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
    fin      = word_q ? sext32(res_full[31:0]) : res_full;
  end

  // Next-state logic: flush wins over everything, including a fresh start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    word_d   = word_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    valid_d  = 1'b0;
    result_d = result_q;
    if (bus.i_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            is_div_d = is_div;
            hi_d     = is_div ? f3[1] : is_mulh;
            word_d   = word_eff;
            qneg_d   = a_neg ^ b_neg;
            rneg_d   = a_neg;
            cnt_d    = word_eff ? CntW'(32) : CntW'(WIDTH);
            opb_d    = b_mag;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            if (is_div) begin
              // Word dividends are left-aligned so the MSB is always consumed first.
              acc_d = {{WIDTH{1'b0}}, (word_eff ? (a_mag << (WIDTH - 32)) : a_mag)};
            end else begin
              acc_d = '0;
            end
            if (is_div && (div_zero || div_ovf)) begin
              result_d = fast_res;
              valid_d  = 1'b1;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d   = acc_it;
          mcand_d = mcand_q << 1;
          opb_d   = is_div_q ? opb_q : (opb_q >> 1);
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            result_d = fin;
            valid_d  = 1'b1;
            state_d  = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
      word_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      word_q   <= word_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Stall is combinational so the start cycle itself already holds the pipeline.
  always_comb begin
    bus.o_busy   = (state_q == StCalc) |
                   ((state_q == StIdle) & bus.i_valid & ~bus.i_flush);
    bus.o_valid  = valid_q;
    bus.o_result = result_q;
  end
endmodule

// File: tb/tb_ysyx_22050078_exu_muldiv.sv
// Directed bench for the iterative mul/div unit: results, latency, stall and abort behaviour.
module tb_ysyx_22050078_exu_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050078_exu_muldiv_if #(.WIDTH(64)) bus ();

  ysyx_22050078_exu_muldiv #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE, wait for the strobe, check latency, result and stall profile.
  task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int   k;
    logic busy_ok;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_func3 = f;
    bus.i_word  = w;
    bus.i_rs1   = a;
    bus.i_rs2   = b;
    #1;
    check_eq({tag, " busy0"}, 64'(bus.o_busy), 64'd1);
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (!bus.o_valid && !bus.o_busy) busy_ok = 1'b0;
    end while (!bus.o_valid && k < 200);
    check_eq({tag, " latency"}, 64'(k), 64'(lat));
    check_eq({tag, " result"}, bus.o_result, exp);
    check_eq({tag, " busy_calc"}, 64'(busy_ok), 64'd1);
    check_eq({tag, " busy_done"}, 64'(bus.o_busy), 64'd0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " pulse"}, 64'(bus.o_valid), 64'd0);
    check_eq({tag, " hold"}, bus.o_result, exp);
  endtask

  initial begin
    int  k;
    logic seen;
    bus.i_valid = 1'b0;
    bus.i_func3 = 3'b000;
    bus.i_word  = 1'b0;
    bus.i_rs1   = '0;
    bus.i_rs2   = '0;
    bus.i_flush = 1'b0;
    #12;
    check_eq("rst valid", 64'(bus.o_valid), 64'd0);
    check_eq("rst result", bus.o_result, 64'd0);
    check_eq("rst busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;

    run_op("MUL",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("MULH",   3'b001, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("MULHU",  3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("MULHSU", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("DIV",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("DIVneg", 3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REMpos", 3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_op("DIVU",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("REMU",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("DIVU0",  3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REMU0",  3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("DIVovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("REMovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("DIVUW",  3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    run_op("MULW",   3'b000, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33);
    run_op("DIVW",   3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("REMW",   3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("DIVWovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("REMUW0", 3'b111, 1'b1, 64'h0000_0000_8000_0003, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_8000_0003, 1);

    // Abort a divide at cycle 10: no strobe, stall drops, last result untouched.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_func3 = 3'b100;
    bus.i_word  = 1'b0;
    bus.i_rs1   = 64'd100;
    bus.i_rs2   = 64'd7;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check_eq("flush busy", 64'(bus.o_busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    check_eq("flush novalid", 64'(seen), 64'd0);
    check_eq("flush result", bus.o_result, 64'hFFFF_FFFF_8000_0003);
    run_op("MUL3x4", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 65);

    // Asynchronous reset mid-multiply clears outputs without waiting for a clock edge.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_func3 = 3'b000;
    bus.i_rs1   = 64'd9;
    bus.i_rs2   = 64'd9;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst valid", 64'(bus.o_valid), 64'd0);
    check_eq("arst result", bus.o_result, 64'd0);
    bus.i_valid = 1'b0;
    #1;
    check_eq("arst busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'b101, 1'b0, 64'd81, 64'd9, 64'd9, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
